uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that serialises bytes onto `RsTx` (USB-RS232). Producers push bytes through a valid/ready port into an internal FIFO; the block drains the FIFO back-to-back at a fixed baud rate. It is the transmit-side counterpart to the receive path that drives the seven-segment display. In `system`, the switch byte is pushed on a single-pulsed `btnU`, and multi-byte messages can be pushed by other logic.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Holds the FSM state enum, the 8N1 frame constants, the default clock and baud rate, and a baud divider helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS       = 10;
  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 9600;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int frame_clks(input int clk_freq, input int baud);
    return FRAME_BITS * baud_div(clk_freq, baud);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte-wide synchronous FIFO with extra-MSB pointers, so full and empty can be told apart without a separate counter.
// The read data is taken combinationally from the head entry.
module uart_sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             wdata,
  input  logic                   pop,
  output logic [7:0]             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;

  // Pointers wrap naturally modulo 2*DEPTH; the caller never pops when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes are queued in a FIFO and drained back-to-back onto RsTx.
// A STOP bit that ends with data queued goes straight into the next START bit, with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   RsTx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            DIV       = baud_div(CLK_FREQ, BAUD);
  localparam int            BW        = $clog2(DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rstx_q, rstx_d;
  logic          busy_q, busy_d;

  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          baud_tick;

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign tx_ready  = !fifo_full;
  assign RsTx      = rstx_q;
  assign busy      = busy_q;
  assign baud_tick = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rstx_d   = rstx_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        rstx_d = 1'b1;
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          rstx_d   = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          rstx_d  = shift_q[0];
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            rstx_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            // Line always shows bit 0 of the shifter, so expose the next bit as we shift.
            shift_d = {1'b0, shift_q[7:1]};
            rstx_d  = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            rstx_d   = 1'b0;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        rstx_d  = 1'b1;
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Looking at the current FIFO state delays busy by one edge after a push into an idle block.
    busy_d = (state_d != ST_IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      rstx_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      rstx_q  <= rstx_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed and random pushes checked every cycle against a queue-and-timer model
// that predicts RsTx, count, tx_ready and busy from the frame timing rules.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD       = 100_000;
  localparam int DEPTH      = 8;
  localparam int DIV        = CLK_FREQ / BAUD;
  localparam int FRAME_CLKS = FRAME_BITS * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       RsTx;
  logic       busy;
  logic [3:0] count;

  uart_tx_fifo #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .RsTx     (RsTx),
    .busy     (busy),
    .count    (count)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] mq[$];
  int         frame_left = 0;
  logic [7:0] cur_byte = 8'h00;
  logic       m_busy = 1'b0;
  bit         last_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic exp_line();
    int p;
    int b;
    if (frame_left == 0) return 1'b1;
    p = FRAME_CLKS - frame_left;
    b = p / DIV;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return cur_byte[b-1];
  endfunction

  // Advance the model across one rising edge, then compare all outputs.
  task automatic step();
    int sz;
    last_acc = 1'b0;
    if (reset) begin
      mq.delete();
      frame_left = 0;
      m_busy     = 1'b0;
    end else begin
      sz       = mq.size();
      last_acc = tx_valid && (sz < DEPTH);
      if (sz > 0 && frame_left <= 1) begin
        cur_byte   = mq.pop_front();
        frame_left = FRAME_CLKS;
      end else if (frame_left > 0) begin
        frame_left--;
      end
      if (last_acc) mq.push_back(tx_data);
      m_busy = (frame_left > 0) || (sz > 0);
    end
    @(posedge clk);
    #1;
    cyc++;
    check("line", 32'(RsTx), 32'(exp_line()));
    check("count", 32'(count), 32'(mq.size()));
    check("tx_ready", 32'(tx_ready), 32'(mq.size() < DEPTH));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic drain();
    int n = 0;
    while ((frame_left != 0 || mq.size() != 0) && n < 5000) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(n < 5000), 32'd1);
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic wait_frame_left(input int target);
    int n = 0;
    while (frame_left != target && n < 3000) begin
      step();
      n++;
    end
    check("wait_timeout", 32'(n < 3000), 32'd1);
  endtask

  task automatic push_seq(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    step();
    tx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int i;

    // Reset
    reset = 1'b1;
    step();
    step();
    check("reset_rstx", 32'(RsTx), 32'd1);
    check("reset_count", 32'(count), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(tx_ready), 32'd1);
    reset = 1'b0;
    step();

    // Single byte
    push_seq(8'h55);
    step();
    check("single_rstx_low", 32'(RsTx), 32'd0);
    check("single_busy_rise", 32'(busy), 32'd1);
    n = 1;
    while (busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("single_busy_len", 32'(n), 32'd101);
    drain();

    // Back-to-back bytes
    push_seq(8'hA3);
    push_seq(8'h0F);
    wait_frame_left(1);
    step();
    check("b2b_no_gap", 32'(RsTx), 32'd0);
    drain();

    // Fill to full, tenth byte rejected
    tx_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tx_data = 8'h30 + 8'(k);
      step();
      if (k == 8) begin
        check("fill_count8", 32'(count), 32'd8);
        check("fill_ready0", 32'(tx_ready), 32'd0);
      end
      if (k == 9) check("fill_reject", 32'(last_acc), 32'd0);
    end
    tx_valid = 1'b0;
    wait_frame_left(1);
    step();
    check("fill_ready_back", 32'(tx_ready), 32'd1);
    check("fill_count7", 32'(count), 32'd7);
    drain();

    // Simultaneous push and pop with count == 3
    for (int k = 0; k < 4; k++) push_seq(8'($urandom));
    check("simul_pre_count", 32'(count), 32'd3);
    wait_frame_left(1);
    push_seq(8'hC7);
    check("simul_count", 32'(count), 32'd3);
    drain();

    // Reset mid-frame during bit 4 of 0xFF
    push_seq(8'hFF);
    push_seq(8'($urandom));
    push_seq(8'($urandom));
    wait_frame_left(FRAME_CLKS - 5 * DIV - 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_rstx", 32'(RsTx), 32'd1);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 300; k++) step();

    // Pointer wrap: 20 bytes with a producer that holds data until accepted
    i = 0;
    n = 0;
    while (i < 20 && n < 4000) begin
      tx_valid = 1'b1;
      tx_data  = 8'(i);
      step();
      if (last_acc) i++;
      n++;
    end
    tx_valid = 1'b0;
    check("wrap_pushed", 32'(i), 32'd20);
    drain();
    check("wrap_count0", 32'(count), 32'd0);

    // Random traffic
    for (int k = 0; k < 2500; k++) begin
      tx_valid = ($urandom_range(0, 6) == 0);
      tx_data  = 8'($urandom);
      step();
    end
    tx_valid = 1'b0;
    drain();
    check("final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
